// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: parity-mode encodings,
// serializer state enumeration and the parity-bit selection helper.
package uart_pkg;

  typedef enum logic [2:0] {
    PAR_NONE  = 3'b000,
    PAR_ODD   = 3'b001,
    PAR_EVEN  = 3'b010,
    PAR_SPACE = 3'b100,
    PAR_MARK  = 3'b101
  } parity_mode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
  } tx_state_t;

  localparam int MAX_DATA_W = 9;

  // Returns {parity_enabled, parity_bit}; unlisted encodings mean no parity.
  // Zero-extension of narrower words does not change the XOR reduction.
  function automatic logic [1:0] parity_select(input logic [2:0] mode,
                                               input logic [MAX_DATA_W-1:0] data);
    logic en;
    logic pbit;
    en   = 1'b1;
    pbit = 1'b0;
    case (mode)
      PAR_ODD:   pbit = ~^data;
      PAR_EVEN:  pbit = ^data;
      PAR_SPACE: pbit = 1'b0;
      PAR_MARK:  pbit = 1'b1;
      default:   en = 1'b0;
    endcase
    return {en, pbit};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-bit pointers, synchronous clear and an
// occupancy output. Read data is the current head word (show-ahead).
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0] PTR_MAX = (AW+1)'(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         wr_en;
  logic         rd_en;

  assign level = wr_ptr - rd_ptr;
  assign full  = (level == PTR_MAX);
  assign empty = (level == '0);
  assign rdata = mem[rd_ptr[AW-1:0]];
  assign wr_en = push & ~full & ~clear;
  assign rd_en = pop & ~empty & ~clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: FIFO-buffered words are framed (start, data LSB-first,
// optional parity, one or two stop bits) with a per-frame latched bit divisor.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 24
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [DATA_W-1:0]             data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [2:0]                    cfg_parity_i,
  input  logic                          cfg_stopbits_i,
  input  logic [DIV_W-1:0]              cfg_divisor_i,
  input  logic                          flush_i,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic                          frame_done_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output tx_state_t                     state_o
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] BIT_ONE = BIT_W'(1);

  // Handshake: data_i is taken on every rising edge where valid_i && ready_o
  // (and flush_i is low); the producer keeps data_i stable while valid_i is
  // high and ready_o is low, and may not withdraw a word once offered.

  tx_state_t         state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              par_en_q, par_en_d;
  logic              par_bit_q, par_bit_d;
  logic              two_stop_q, two_stop_d;
  logic              tx_d;
  logic              load;
  logic              frame_end;
  logic              push;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DIV_W-1:0]  div_in;
  logic [1:0]        par_sel;
  logic              bit_end;

  assign push    = valid_i & ~fifo_full & ~flush_i;
  assign ready_o = ~fifo_full;
  assign div_in  = (cfg_divisor_i == '0) ? DIV_ONE : cfg_divisor_i;
  assign par_sel = parity_select(cfg_parity_i, MAX_DATA_W'(fifo_data));
  assign bit_end = (cnt_q == '0);

  sync_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_i),
    .clear (flush_i),
    .push  (push),
    .wdata (data_i),
    .pop   (load),
    .rdata (fifo_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level_o)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      div_q      <= DIV_ONE;
      shift_q    <= '0;
      bit_q      <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      tx_o       <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      shift_q    <= shift_d;
      bit_q      <= bit_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      two_stop_q <= two_stop_d;
      tx_o       <= tx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    shift_d    = shift_q;
    bit_d      = bit_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    two_stop_d = two_stop_q;
    load       = 1'b0;
    frame_end  = 1'b0;
    tx_d       = 1'b1;

    if (state_q != S_IDLE && !bit_end) cnt_d = cnt_q - DIV_ONE;

    case (state_q)
      S_IDLE: load = ~fifo_empty;
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          cnt_d   = div_q - DIV_ONE;
          bit_d   = BIT_LAST;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = div_q - DIV_ONE;
          if (bit_q == '0) begin
            state_d = par_en_q ? S_PARITY : S_STOP1;
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q - BIT_ONE;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP1;
          cnt_d   = div_q - DIV_ONE;
        end
      end
      S_STOP1: begin
        if (bit_end) begin
          if (two_stop_q) begin
            state_d = S_STOP2;
            cnt_d   = div_q - DIV_ONE;
          end else begin
            frame_end = 1'b1;
          end
        end
      end
      S_STOP2: frame_end = bit_end;
      default: state_d = S_IDLE;
    endcase

    // A finished frame chains straight into the next queued word.
    if (frame_end) begin
      if (!fifo_empty) load = 1'b1;
      else state_d = S_IDLE;
    end

    if (load) begin
      state_d    = S_START;
      div_d      = div_in;
      cnt_d      = div_in - DIV_ONE;
      shift_d    = fifo_data;
      par_en_d   = par_sel[1];
      par_bit_d  = par_sel[0];
      two_stop_d = cfg_stopbits_i;
    end

    if (flush_i) begin
      state_d = S_IDLE;
      load    = 1'b0;
    end

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_bit_d;
      default:  tx_d = 1'b1;
    endcase
  end

  assign busy_o       = (state_q != S_IDLE);
  assign frame_done_o = frame_end & ~flush_i;
  assign state_o      = state_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: expected line waveforms are built from the
// frame rules (bit list times divisor) and compared cycle by cycle.
module tb_uart_tx_serializer;
  import uart_pkg::*;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int DIV_W      = 24;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

  logic              clk_i;
  logic              rst_i;
  logic [DATA_W-1:0] data_i;
  logic              valid_i;
  logic              ready_o;
  logic [2:0]        cfg_parity_i;
  logic              cfg_stopbits_i;
  logic [DIV_W-1:0]  cfg_divisor_i;
  logic              flush_i;
  logic              tx_o;
  logic              busy_o;
  logic              frame_done_o;
  logic [LVL_W-1:0]  level_o;
  tx_state_t         state_o;

  uart_tx_serializer #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .DIV_W      (DIV_W)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .data_i         (data_i),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .cfg_parity_i   (cfg_parity_i),
    .cfg_stopbits_i (cfg_stopbits_i),
    .cfg_divisor_i  (cfg_divisor_i),
    .flush_i        (flush_i),
    .tx_o           (tx_o),
    .busy_o         (busy_o),
    .frame_done_o   (frame_done_o),
    .level_o        (level_o),
    .state_o        (state_o)
  );

  // Clock and watchdog
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  int                cmp_cnt = 0;
  int                fail_cnt = 0;
  logic              exp_q[$];
  logic              got_q[$];
  int                exp_done_q[$];
  int                got_done_q[$];
  logic [DATA_W-1:0] word_q[$];
  logic              rec_en = 1'b0;
  int                done_total = 0;

  always @(negedge clk_i) begin
    if (frame_done_o) done_total <= done_total + 1;
    if (rec_en) begin
      if (frame_done_o) got_done_q.push_back(got_q.size());
      got_q.push_back(tx_o);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: a frame is a list of bit levels, each held n cycles.
  task automatic model_frame(input logic [DATA_W-1:0] d, input int mode,
                             input int two_stop, input int div);
    int n;
    int ones;
    int pb;
    n    = (div == 0) ? 1 : div;
    ones = 0;
    repeat (n) exp_q.push_back(1'b0);
    for (int i = 0; i < DATA_W; i++) begin
      repeat (n) exp_q.push_back(d[i]);
      ones += int'(d[i]);
    end
    case (mode)
      1: pb = (ones % 2 == 0) ? 1 : 0;
      2: pb = ones % 2;
      4: pb = 0;
      5: pb = 1;
      default: pb = -1;
    endcase
    if (pb >= 0) repeat (n) exp_q.push_back(pb[0]);
    repeat (n * ((two_stop != 0) ? 2 : 1)) exp_q.push_back(1'b1);
    exp_done_q.push_back(exp_q.size() - 1);
  endtask

  task automatic begin_model();
    exp_q.delete();
    got_q.delete();
    exp_done_q.delete();
    got_done_q.delete();
    word_q.delete();
    exp_q.push_back(1'b1);
  endtask

  task automatic set_cfg(input int mode, input int two_stop, input int div);
    cfg_parity_i   = 3'(mode);
    cfg_stopbits_i = (two_stop != 0);
    cfg_divisor_i  = DIV_W'(div);
  endtask

  // Driver: called at posedge+1; returns at posedge+1 after the handshake.
  task automatic push_word(input logic [DATA_W-1:0] w);
    int   guard;
    logic hs;
    guard   = 0;
    hs      = 1'b0;
    data_i  = w;
    valid_i = 1'b1;
    while (!hs && guard < 400) begin
      hs = ready_o;
      @(posedge clk_i);
      #1;
      guard++;
    end
    valid_i = 1'b0;
    check("push_accepted", 32'(hs), 32'd1);
  endtask

  task automatic send_batch();
    foreach (word_q[i]) begin
      push_word(word_q[i]);
      if (i == 0) rec_en = 1'b1;
    end
  endtask

  task automatic finish_wave(input string tag);
    int guard;
    int mism;
    int dmism;
    guard = 0;
    mism  = 0;
    dmism = 0;
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    while (got_q.size() < exp_q.size() && guard < 5000) begin
      @(posedge clk_i);
      guard++;
    end
    #1;
    rec_en = 1'b0;
    check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] !== exp_q[i]) mism++;
    check({tag, "_bits_wrong"}, 32'(mism), 32'd0);
    check({tag, "_done_cnt"}, 32'(got_done_q.size()), 32'(exp_done_q.size()));
    for (int i = 0; i < exp_done_q.size() && i < got_done_q.size(); i++)
      if (got_done_q[i] != exp_done_q[i]) dmism++;
    check({tag, "_done_pos_wrong"}, 32'(dmism), 32'd0);
  endtask

  initial begin
    int mode;
    int stp;
    int div;
    int nw;
    int done_before;
    logic [DATA_W-1:0] w;

    rst_i   = 1'b0;
    data_i  = '0;
    valid_i = 1'b0;
    flush_i = 1'b0;
    set_cfg(0, 0, 1);
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    check("rst_tx", 32'(tx_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_level", 32'(level_o), 32'd0);
    check("rst_done", 32'(frame_done_o), 32'd0);
    check("rst_state", 32'(state_o), 32'(S_IDLE));

    // Odd parity, 1 stop, divisor 4, word 0x3A
    begin_model();
    set_cfg(1, 0, 4);
    word_q.push_back(8'h3A);
    model_frame(8'h3A, 1, 0, 4);
    done_before = done_total;
    send_batch();
    finish_wave("odd_3a");
    check("odd_3a_frame_cycles", 32'(got_q.size()), 32'd47);
    check("odd_3a_one_pulse", 32'(done_total - done_before), 32'd1);

    // No parity, 2 stop, divisor 0, word 0xFF
    begin_model();
    set_cfg(0, 1, 0);
    word_q.push_back(8'hFF);
    model_frame(8'hFF, 0, 1, 0);
    send_batch();
    finish_wave("div0_ff");
    check("div0_ff_done_index", 32'(got_done_q.size() > 0 ? got_done_q[0] : -1), 32'd11);

    // 17 words into a 16-deep FIFO while the line is busy
    begin_model();
    set_cfg(0, 0, 4);
    for (int i = 0; i < 17; i++) begin
      w = DATA_W'($urandom);
      word_q.push_back(w);
      model_frame(w, 0, 0, 4);
    end
    send_batch();
    check("fill_level", 32'(level_o), 32'(FIFO_DEPTH));
    check("fill_ready", 32'(ready_o), 32'd0);
    finish_wave("fill17");

    // Config change mid-frame affects only the following frame
    begin_model();
    set_cfg(2, 0, 4);
    word_q.push_back(8'hC5);
    word_q.push_back(8'h5C);
    model_frame(8'hC5, 2, 0, 4);
    model_frame(8'h5C, 2, 1, 8);
    send_batch();
    repeat (10) @(posedge clk_i);
    #1;
    cfg_divisor_i  = DIV_W'(8);
    cfg_stopbits_i = 1'b1;
    finish_wave("cfg_change");

    // Randomized batches
    for (int b = 0; b < 6; b++) begin
      begin_model();
      mode = $urandom_range(0, 7);
      stp  = $urandom_range(0, 1);
      div  = $urandom_range(0, 5);
      nw   = $urandom_range(1, 4);
      set_cfg(mode, stp, div);
      for (int i = 0; i < nw; i++) begin
        w = DATA_W'($urandom);
        word_q.push_back(w);
        model_frame(w, mode, stp, div);
      end
      send_batch();
      finish_wave($sformatf("rand%0d", b));
    end

    // Flush during data bit 3 with 5 words queued behind the active one
    set_cfg(0, 0, 4);
    push_word(8'h00);
    for (int i = 0; i < 5; i++) push_word(DATA_W'($urandom));
    repeat (13) @(posedge clk_i);
    #1;
    check("flush_pre_state", 32'(state_o), 32'(S_DATA));
    check("flush_pre_tx", 32'(tx_o), 32'd0);
    check("flush_pre_level", 32'(level_o), 32'd5);
    done_before = done_total;
    flush_i = 1'b1;
    valid_i = 1'b1;
    data_i  = 8'h55;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    valid_i = 1'b0;
    check("flush_tx", 32'(tx_o), 32'd1);
    check("flush_level", 32'(level_o), 32'd0);
    check("flush_busy", 32'(busy_o), 32'd0);
    check("flush_ready", 32'(ready_o), 32'd1);
    repeat (6) @(posedge clk_i);
    #1;
    check("flush_after_tx", 32'(tx_o), 32'd1);
    check("flush_push_dropped", 32'(level_o), 32'd0);
    check("flush_no_done", 32'(done_total - done_before), 32'd0);

    // Asynchronous reset while the parity bit is on the line
    set_cfg(2, 0, 4);
    push_word(8'h03);
    push_word(8'h81);
    repeat (37) @(posedge clk_i);
    #1;
    check("rstmid_pre_state", 32'(state_o), 32'(S_PARITY));
    check("rstmid_pre_tx", 32'(tx_o), 32'd0);
    check("rstmid_pre_level", 32'(level_o), 32'd1);
    #2;
    rst_i = 1'b0;
    #1;
    check("rstmid_tx", 32'(tx_o), 32'd1);
    check("rstmid_busy", 32'(busy_o), 32'd0);
    check("rstmid_done", 32'(frame_done_o), 32'd0);
    check("rstmid_level", 32'(level_o), 32'd0);
    check("rstmid_ready", 32'(ready_o), 32'd1);
    check("rstmid_state", 32'(state_o), 32'(S_IDLE));
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Line recovers after reset
    begin_model();
    set_cfg(5, 0, 2);
    word_q.push_back(8'hA7);
    model_frame(8'hA7, 5, 0, 2);
    send_batch();
    finish_wave("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
